// File: rtl/im_mem_burst_pkg.sv
// im_mem_burst_pkg: shared instruction-RAM defaults and burst FSM state encodings.
package im_mem_burst_pkg;
  localparam int INS_RAM_DATA_WIDTH = 16;
  localparam int INS_RAM_DEPTH = 1024;
  localparam int INS_RAM_NUM_PIPE = 1;
  localparam int IM_MAX_BURST = 256;
  localparam int IM_FIFO_DEPTH = 8;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BURST = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
endpackage

// File: rtl/im_rsp_fifo.sv
// im_rsp_fifo: synchronous fall-through FIFO with occupancy count.
module im_rsp_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp == PW'(DEPTH-1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == PW'(DEPTH-1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
endmodule

// File: rtl/sdp_bram.sv
// sdp_bram: simple dual-port RAM, read-before-write, latency 1+NUM_PIPE.
module sdp_bram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int NUM_PIPE = 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] pipe [NUM_PIPE+1];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) pipe[0] <= mem[raddr];
    for (int i = 1; i <= NUM_PIPE; i++) pipe[i] <= pipe[i-1];
  end
  assign rdata = pipe[NUM_PIPE];
endmodule

// File: rtl/im_mem_burst.sv
// im_mem_burst: instruction RAM with credit-controlled burst fetch and response FIFO.
// Define IM_PARITY_EN to store even parity per word and report the first failing read address.
module im_mem_burst
  import im_mem_burst_pkg::*;
#(
  parameter int DATA_WIDTH = INS_RAM_DATA_WIDTH,
  parameter int DEPTH = INS_RAM_DEPTH,
  parameter int NUM_PIPE = INS_RAM_NUM_PIPE,
  parameter int MAX_BURST = IM_MAX_BURST,
  parameter int FIFO_DEPTH = IM_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             wr_en,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [$clog2(DEPTH)-1:0]         req_addr,
  input  logic [$clog2(MAX_BURST+1)-1:0]   req_len,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_last,
`ifdef IM_PARITY_EN
  output logic                             par_err,
  output logic [$clog2(DEPTH)-1:0]         par_err_addr,
`endif
  output logic                             busy
);
  localparam int L = 1 + NUM_PIPE;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_BURST+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
`ifdef IM_PARITY_EN
  localparam int RW = DATA_WIDTH + 1;
`else
  localparam int RW = DATA_WIDTH;
`endif
  state_t state;
  logic [AW-1:0] addr;
  logic [LW-1:0] rem;
  logic [CW-1:0] outstanding, fifo_count;
  logic [L-1:0] vld, lst;
  logic [RW-1:0] ram_din, rdata;
  logic issue, pop;
  assign pop = rsp_valid && rsp_ready;
  // Items in the RAM pipe plus FIFO contents may never exceed FIFO capacity.
  assign issue = state == S_BURST && (32'(outstanding) + 32'(fifo_count) - 32'(pop)) < FIFO_DEPTH;
  assign req_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign rsp_valid = fifo_count != '0;
`ifdef IM_PARITY_EN
  assign ram_din = {^din, din};
`else
  assign ram_din = din;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      addr <= '0;
      rem <= '0;
      outstanding <= '0;
      vld <= '0;
      lst <= '0;
    end else begin
      vld <= L'({vld, issue});
      lst <= L'({lst, issue && rem == LW'(1)});
      outstanding <= outstanding + CW'(issue) - CW'(vld[L-1]);
      if (state == S_IDLE && req_valid && req_len != '0) begin
        state <= S_BURST;
        addr <= req_addr;
        rem <= req_len;
      end
      if (issue) begin
        addr <= addr + 1'b1;
        rem <= rem - 1'b1;
        if (rem == LW'(1)) state <= S_DRAIN;
      end
      if (state == S_DRAIN && outstanding == '0 && fifo_count == '0) state <= S_IDLE;
    end
  end
  sdp_bram #(.WIDTH(RW), .DEPTH(DEPTH), .NUM_PIPE(NUM_PIPE)) u_ram (
    .clk(clk), .we(wr_en), .waddr(wr_addr), .wdata(ram_din),
    .re(issue), .raddr(addr), .rdata(rdata)
  );
  im_rsp_fifo #(.WIDTH(DATA_WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(vld[L-1]), .din({lst[L-1], rdata[DATA_WIDTH-1:0]}),
    .pop(pop), .dout({rsp_last, rsp_data}), .count(fifo_count)
  );
`ifdef IM_PARITY_EN
  logic [AW-1:0] pa [L];
  always_ff @(posedge clk) begin
    pa[0] <= addr;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      par_err <= 1'b0;
      par_err_addr <= '0;
    end else if (vld[L-1] && ^rdata && !par_err) begin
      par_err <= 1'b1;
      par_err_addr <= pa[L-1];
    end
  end
`endif
endmodule
